// File: rtl/sc_frog_point_driver.sv
// sc_frog_point_driver
//   Frog-side producer of the point matrix consumed by the collision
//   comparator. Tracks the frog row/column, the game FSM, lives and score,
//   and drives eight one-hot row buses (row 0 is the goal row).
//
//   Optional feature: define SC_FROGPOINT_WRAP_EN for horizontal wrap-around
//   (left at the MSB column goes to column 0, right at column 0 goes to the
//   MSB column). Without it, horizontal moves clamp at the edges. Downward
//   moves always clamp at row 7.
//
// Ports
//   SC_FROGPOINT_CLOCK_50          clock
//   SC_FROGPOINT_RESET_InHigh      synchronous reset, active-high
//   SC_FROGPOINT_start_In          start/restart pulse
//   SC_FROGPOINT_up_In/down_In     move pulses toward row 0 / row 7
//   SC_FROGPOINT_left_In/right_In  move pulses toward MSB / LSB column
//   SC_FROGPOINT_collision_In      collision flag from the comparator
//   SC_FROGPOINT_data0..7_OutBus   point rows, one-hot at the frog, else 0
//   SC_FROGPOINT_lives_OutBus      remaining lives
//   SC_FROGPOINT_score_OutBus      goals reached, wraps mod 256
//   SC_FROGPOINT_state_OutBus      FSM state code
//   SC_FROGPOINT_gameover_Out      high in GAMEOVER
module sc_frog_point_driver #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned HIT_CYCLES = 16,
  parameter int unsigned START_ROW  = 7,
  parameter int unsigned START_COL  = 3
) (
  input  logic                 SC_FROGPOINT_CLOCK_50,
  input  logic                 SC_FROGPOINT_RESET_InHigh,
  input  logic                 SC_FROGPOINT_start_In,
  input  logic                 SC_FROGPOINT_up_In,
  input  logic                 SC_FROGPOINT_down_In,
  input  logic                 SC_FROGPOINT_left_In,
  input  logic                 SC_FROGPOINT_right_In,
  input  logic                 SC_FROGPOINT_collision_In,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data0_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data1_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data2_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data3_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data4_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data5_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data6_OutBus,
  output logic [DATAWIDTH-1:0] SC_FROGPOINT_data7_OutBus,
  output logic [2:0]           SC_FROGPOINT_lives_OutBus,
  output logic [7:0]           SC_FROGPOINT_score_OutBus,
  output logic [2:0]           SC_FROGPOINT_state_OutBus,
  output logic                 SC_FROGPOINT_gameover_Out
);

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned COL_W    = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam int unsigned HIT_W    = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PLAY     = 3'd1;
  localparam logic [2:0] HIT      = 3'd2;
  localparam logic [2:0] GOAL     = 3'd3;
  localparam logic [2:0] GAMEOVER = 3'd4;

  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(DATAWIDTH - 1);
  localparam logic [HIT_W-1:0] HIT_LOAD  = HIT_W'(HIT_CYCLES - 1);
  localparam logic [2:0]       LIVES_LOAD = 3'(LIVES_INIT);

  // Registered game state
  logic [2:0]           state_q,  state_n;
  logic [ROW_W-1:0]     row_q,    row_n;
  logic [COL_W-1:0]     col_q,    col_n;
  logic [2:0]           lives_q,  lives_n;
  logic [7:0]           score_q,  score_n;
  logic [HIT_W-1:0]     hit_q,    hit_n;
  logic                 gameover_q;
  logic [DATAWIDTH-1:0] rows_q [NUM_ROWS];
  logic [DATAWIDTH-1:0] rows_n [NUM_ROWS];

  // State register: every output comes straight from a flop
  always_ff @(posedge SC_FROGPOINT_CLOCK_50) begin
    if (SC_FROGPOINT_RESET_InHigh) begin
      state_q    <= IDLE;
      row_q      <= ROW_START;
      col_q      <= COL_START;
      lives_q    <= LIVES_LOAD;
      score_q    <= 8'd0;
      hit_q      <= '0;
      gameover_q <= 1'b0;
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
        rows_q[r] <= (ROW_W'(r) == ROW_START) ? (DATAWIDTH'(1) << COL_START) : '0;
      end
    end else begin
      state_q    <= state_n;
      row_q      <= row_n;
      col_q      <= col_n;
      lives_q    <= lives_n;
      score_q    <= score_n;
      hit_q      <= hit_n;
      gameover_q <= (state_n == GAMEOVER);
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
        rows_q[r] <= rows_n[r];
      end
    end
  end

  // Next-state, position, lives and score
  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    col_n   = col_q;
    lives_n = lives_q;
    score_n = score_q;
    hit_n   = hit_q;

    case (state_q)
      IDLE: begin
        if (SC_FROGPOINT_start_In) begin
          state_n = PLAY;
        end
      end

      PLAY: begin
        // Collision wins over any move in the same cycle
        if (SC_FROGPOINT_collision_In) begin
          if (lives_q <= 3'd1) begin
            lives_n = 3'd0;
            state_n = GAMEOVER;
          end else begin
            lives_n = lives_q - 3'd1;
            hit_n   = HIT_LOAD;
            state_n = HIT;
          end
        end else if (SC_FROGPOINT_up_In) begin
          if (row_q == ROW_W'(1)) begin
            row_n   = '0;
            score_n = score_q + 8'd1;
            state_n = GOAL;
          end else if (row_q != '0) begin
            row_n = row_q - ROW_W'(1);
          end
        end else if (SC_FROGPOINT_down_In) begin
          if (row_q != ROW_LAST) begin
            row_n = row_q + ROW_W'(1);
          end
        end else if (SC_FROGPOINT_left_In) begin
          if (col_q != COL_LAST) begin
            col_n = col_q + COL_W'(1);
          end else begin
`ifdef SC_FROGPOINT_WRAP_EN
            col_n = '0;
`else
            col_n = col_q;
`endif
          end
        end else if (SC_FROGPOINT_right_In) begin
          if (col_q != '0) begin
            col_n = col_q - COL_W'(1);
          end else begin
`ifdef SC_FROGPOINT_WRAP_EN
            col_n = COL_LAST;
`else
            col_n = col_q;
`endif
          end
        end
      end

      GOAL: begin
        // Frog was shown at row 0 for this single cycle; respawn now
        row_n   = ROW_START;
        col_n   = COL_START;
        state_n = PLAY;
      end

      HIT: begin
        if (hit_q == '0) begin
          row_n   = ROW_START;
          col_n   = COL_START;
          state_n = PLAY;
        end else begin
          hit_n = hit_q - HIT_W'(1);
        end
      end

      GAMEOVER: begin
        if (SC_FROGPOINT_start_In) begin
          lives_n = LIVES_LOAD;
          score_n = 8'd0;
          row_n   = ROW_START;
          col_n   = COL_START;
          state_n = PLAY;
        end
      end

      default: begin
        state_n = IDLE;
        row_n   = ROW_START;
        col_n   = COL_START;
        lives_n = LIVES_LOAD;
        score_n = 8'd0;
        hit_n   = '0;
      end
    endcase
  end

  // Row decode from the next position so the buses line up with the state
  always_comb begin
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      rows_n[r] = '0;
      if ((state_n != GAMEOVER) && (row_n == ROW_W'(r))) begin
        rows_n[r] = DATAWIDTH'(1) << col_n;
      end
    end
  end

  assign SC_FROGPOINT_data0_OutBus = rows_q[0];
  assign SC_FROGPOINT_data1_OutBus = rows_q[1];
  assign SC_FROGPOINT_data2_OutBus = rows_q[2];
  assign SC_FROGPOINT_data3_OutBus = rows_q[3];
  assign SC_FROGPOINT_data4_OutBus = rows_q[4];
  assign SC_FROGPOINT_data5_OutBus = rows_q[5];
  assign SC_FROGPOINT_data6_OutBus = rows_q[6];
  assign SC_FROGPOINT_data7_OutBus = rows_q[7];
  assign SC_FROGPOINT_lives_OutBus = lives_q;
  assign SC_FROGPOINT_score_OutBus = score_q;
  assign SC_FROGPOINT_state_OutBus = state_q;
  assign SC_FROGPOINT_gameover_Out = gameover_q;

endmodule
